// File: rtl/data_mem_responder.sv
// Responder for the CPU data-memory port: word RAM plus LED, cycle-counter and compare-timer registers.
// Optional macro DATA_MEM_TIMER_EN enables the CMP/STATUS registers and timer_irq.
module data_mem_responder #(
    parameter int unsigned DEPTH         = 1024,
    parameter logic [31:0] IO_BASE       = 32'h8000_0000,
    parameter logic [31:0] UNMAPPED_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ram_addr,
    input  logic        ram_we,
    input  logic [31:0] ram_wdata,
    output logic [31:0] ram_rdata,
    output logic [15:0] led,
    output logic        timer_irq
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   mem [DEPTH];
    logic [29:0]   word_s;
    logic [29:0]   io_word_s;
    logic [AW-1:0] ram_idx_s;
    logic          is_io_s;
    logic          ram_hit_s;
    logic          sel_led_s;
    logic          sel_cyc_s;
    logic          unused_addr_bits;

    logic [31:0] ram_rdata_d, ram_rdata_q;
    logic [15:0] led_d, led_q;
    logic [31:0] cycle_d, cycle_q;

    assign word_s           = ram_addr[31:2];
    assign is_io_s          = (ram_addr >= IO_BASE);
    assign ram_hit_s        = !is_io_s && ({2'b00, word_s} < DEPTH);
    assign ram_idx_s        = word_s[AW-1:0];
    assign io_word_s        = word_s - IO_BASE[31:2];
    assign sel_led_s        = is_io_s && (io_word_s == 30'd0);
    assign sel_cyc_s        = is_io_s && (io_word_s == 30'd1);
    assign unused_addr_bits = ^ram_addr[1:0];

`ifdef DATA_MEM_TIMER_EN
    logic        sel_cmp_s;
    logic        sel_sts_s;
    logic [31:0] cmp_d, cmp_q;
    logic        en_d, en_q;
    logic        match_d, match_q;

    assign sel_cmp_s = is_io_s && (io_word_s == 30'd2);
    assign sel_sts_s = is_io_s && (io_word_s == 30'd3);

    // Compare/status next state; a match on this edge overrides a same-cycle clear.
    always_comb begin
        cmp_d   = cmp_q;
        en_d    = en_q;
        match_d = match_q;
        if (ram_we && sel_cmp_s) begin
            cmp_d = ram_wdata;
        end else begin
            cmp_d = cmp_q;
        end
        if (ram_we && sel_sts_s) begin
            en_d = ram_wdata[1];
            if (ram_wdata[0]) begin
                match_d = 1'b0;
            end else begin
                match_d = match_q;
            end
        end else begin
            en_d = en_q;
        end
        if (en_q && (cycle_q == cmp_q)) begin
            match_d = 1'b1;
        end else begin
            match_d = match_d;
        end
    end

    // Timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_q   <= 32'hFFFF_FFFF;
            en_q    <= 1'b0;
            match_q <= 1'b0;
        end else begin
            cmp_q   <= cmp_d;
            en_q    <= en_d;
            match_q <= match_d;
        end
    end

    assign timer_irq = match_q;
`else
    assign timer_irq = 1'b0;
`endif

    // Read mux and LED/counter next state; reads see pre-edge register values.
    always_comb begin
        cycle_d     = cycle_q + 32'd1;
        led_d       = led_q;
        ram_rdata_d = UNMAPPED_DATA;
        if (ram_we && sel_led_s) begin
            led_d = ram_wdata[15:0];
        end else begin
            led_d = led_q;
        end
        if (ram_hit_s) begin
            ram_rdata_d = mem[ram_idx_s];
        end else if (sel_led_s) begin
            ram_rdata_d = {16'h0000, led_q};
        end else if (sel_cyc_s) begin
            ram_rdata_d = cycle_q;
`ifdef DATA_MEM_TIMER_EN
        end else if (sel_cmp_s) begin
            ram_rdata_d = cmp_q;
        end else if (sel_sts_s) begin
            ram_rdata_d = {30'h0, en_q, match_q};
`endif
        end else begin
            ram_rdata_d = UNMAPPED_DATA;
        end
    end

    // Read data, LED and cycle counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_rdata_q <= 32'h0000_0000;
            led_q       <= 16'h0000;
            cycle_q     <= 32'h0000_0000;
        end else begin
            ram_rdata_q <= ram_rdata_d;
            led_q       <= led_d;
            cycle_q     <= cycle_d;
        end
    end

    // RAM storage is not reset; out-of-range writes never reach the array.
    always_ff @(posedge clk) begin
        if (ram_we && ram_hit_s) begin
            mem[ram_idx_s] <= ram_wdata;
        end
    end

    assign ram_rdata = ram_rdata_q;
    assign led       = led_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (default parameters).
module tb_data_mem_responder;

    localparam logic [31:0] IO = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ram_addr  = 32'h0;
    logic        ram_we    = 1'b0;
    logic [31:0] ram_wdata = 32'h0;
    logic [31:0] ram_rdata;
    logic [15:0] led;
    logic        timer_irq;

    int          ncmp = 0;
    int          nerr = 0;
    logic [31:0] va, vb, cmpv;

    data_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .led       (led),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one access, then return 1 time unit after the capturing edge.
    task automatic cyc(input logic [31:0] a, input logic we, input logic [31:0] wd);
        ram_addr  = a;
        ram_we    = we;
        ram_wdata = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", ram_rdata, 32'h0);
        chk("rst_led", {16'h0, led}, 32'h0);
        chk("rst_irq", {31'h0, timer_irq}, 32'h0);
        rst = 1'b0;

        cyc(IO + 32'h4, 1'b0, 32'h0);
        chk("cycle_first", ram_rdata, 32'h0);

        cyc(32'h10, 1'b1, 32'hCAFE_0001);
        cyc(32'h10, 1'b1, 32'h1234_5678);
        chk("ram_read_first", ram_rdata, 32'hCAFE_0001);
        cyc(32'h10, 1'b0, 32'h0);
        chk("ram_read", ram_rdata, 32'h1234_5678);
        cyc(32'h13, 1'b0, 32'h0);
        chk("ram_low_bits_ignored", ram_rdata, 32'h1234_5678);

        cyc(32'h0, 1'b1, 32'h1111_1111);
        cyc(32'hFFC, 1'b1, 32'h2222_2222);
        cyc(32'h1000, 1'b1, 32'hA5A5_A5A5);
        chk("oor_read_on_write", ram_rdata, 32'h0);
        cyc(32'h0, 1'b0, 32'h0);
        chk("ram0_unchanged", ram_rdata, 32'h1111_1111);
        cyc(32'hFFC, 1'b0, 32'h0);
        chk("ram_last_word", ram_rdata, 32'h2222_2222);
        cyc(32'h1000, 1'b0, 32'h0);
        chk("oor_read", ram_rdata, 32'h0);
        cyc(32'h4000_0000, 1'b0, 32'h0);
        chk("gap_read", ram_rdata, 32'h0);

        cyc(IO, 1'b1, 32'hFFFF_BEEF);
        chk("led_read_first", ram_rdata, 32'h0);
        chk("led_after_write", {16'h0, led}, 32'h0000_BEEF);
        cyc(IO, 1'b0, 32'h0);
        chk("led_readback", ram_rdata, 32'h0000_BEEF);
        cyc(IO + 32'h10, 1'b1, 32'h5555_5555);
        chk("io_unmapped_wr", ram_rdata, 32'h0);
        cyc(IO + 32'h10, 1'b0, 32'h0);
        chk("io_unmapped_rd", ram_rdata, 32'h0);
        chk("led_held", {16'h0, led}, 32'h0000_BEEF);

        cyc(IO + 32'h4, 1'b0, 32'h0);
        va = ram_rdata;
        repeat (4) cyc(32'h0, 1'b0, 32'h0);
        cyc(IO + 32'h4, 1'b0, 32'h0);
        vb = ram_rdata;
        chk("cycle_delta5", vb - va, 32'd5);
        cyc(IO + 32'h4, 1'b1, 32'h0);
        va = ram_rdata;
        cyc(IO + 32'h4, 1'b0, 32'h0);
        chk("cycle_write_ignored", ram_rdata, va + 32'd1);

`ifdef DATA_MEM_TIMER_EN
        cyc(IO + 32'h8, 1'b0, 32'h0);
        chk("cmp_reset", ram_rdata, 32'hFFFF_FFFF);
        cyc(IO + 32'h4, 1'b0, 32'h0);
        cmpv = ram_rdata + 32'd20;
        cyc(IO + 32'h8, 1'b1, cmpv);
        cyc(IO + 32'hC, 1'b1, 32'h2);
        chk("status_pre_en", ram_rdata, 32'h0);
        for (int i = 3; i < 20; i++) begin
            cyc(IO + 32'hC, 1'b0, 32'h0);
            chk("status_before_match", ram_rdata, 32'h2);
        end
        chk("irq_before_match", {31'h0, timer_irq}, 32'h0);
        cyc(IO + 32'hC, 1'b0, 32'h0);
        chk("status_on_match_edge", ram_rdata, 32'h2);
        chk("irq_on_match", {31'h0, timer_irq}, 32'h1);
        cyc(IO + 32'hC, 1'b0, 32'h0);
        chk("status_matched", ram_rdata, 32'h3);
        cyc(IO + 32'hC, 1'b1, 32'h3);
        chk("status_clear_rf", ram_rdata, 32'h3);
        chk("irq_cleared", {31'h0, timer_irq}, 32'h0);
        cyc(IO + 32'hC, 1'b0, 32'h0);
        chk("status_after_clear", ram_rdata, 32'h2);

        cyc(IO + 32'h4, 1'b0, 32'h0);
        cmpv = ram_rdata + 32'd5;
        cyc(IO + 32'h8, 1'b1, cmpv);
        repeat (3) cyc(IO + 32'hC, 1'b0, 32'h0);
        cyc(IO + 32'hC, 1'b1, 32'h3);
        chk("irq_set_wins", {31'h0, timer_irq}, 32'h1);
        cyc(IO + 32'hC, 1'b0, 32'h0);
        chk("status_set_wins", ram_rdata, 32'h3);
`else
        cyc(IO + 32'h8, 1'b1, 32'h40);
        chk("cmp_unmapped_wr", ram_rdata, 32'h0);
        cyc(IO + 32'hC, 1'b1, 32'h2);
        chk("sts_unmapped_wr", ram_rdata, 32'h0);
        cyc(IO + 32'h8, 1'b0, 32'h0);
        chk("cmp_unmapped_rd", ram_rdata, 32'h0);
        cyc(IO + 32'hC, 1'b0, 32'h0);
        chk("sts_unmapped_rd", ram_rdata, 32'h0);
        for (int i = 0; i < 80; i++) begin
            cyc(IO + 32'h4, 1'b0, 32'h0);
            chk("irq_tied_low", {31'h0, timer_irq}, 32'h0);
        end
`endif

        cyc(IO, 1'b0, 32'h0);
        chk("led_before_rst", ram_rdata, 32'h0000_BEEF);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_led", {16'h0, led}, 32'h0);
        chk("async_rst_rdata", ram_rdata, 32'h0);
        chk("async_rst_irq", {31'h0, timer_irq}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(IO + 32'h4, 1'b0, 32'h0);
        chk("cycle_after_rst", ram_rdata, 32'h0);
        cyc(32'h10, 1'b0, 32'h0);
        chk("ram_survives_rst", ram_rdata, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
